// File: rtl/spart_pkg.sv
// Shared SPART constants used by both the receive- and transmit-side buffers.
package spart_pkg;

    localparam int SPART_DATA_W        = 8;
    localparam int SPART_RX_FIFO_DEPTH = 8;

endpackage : spart_pkg

// File: rtl/spart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, read-enabled registered output.
module spart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage carries no reset; only the output register has a defined reset value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : spart_fifo_mem

// File: rtl/spart_rx_fifo.sv
// Receive buffer behind the SPART: captures a byte per rda rising edge, acknowledges it,
// and hands bytes to the processor through a pop/valid handshake with sticky overflow.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int DATA_W = SPART_DATA_W,
    parameter int DEPTH  = SPART_RX_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rda,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rda_ack,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic              rda_q;
    logic              push;
    logic              push_ok;
    logic              pop_ok;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push    = rda & ~rda_q;
    // A pop on a full FIFO frees the slot being written on the same edge.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda_q    <= 1'b0;
            rda_ack  <= 1'b0;
            rd_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rda_q    <= rda;
            rda_ack  <= push;
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    spart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule : spart_rx_fifo

// File: tb/tb_spart_rx_fifo.sv
// Directed scoreboard bench for spart_rx_fifo at DATA_W=8, DEPTH=8.
module tb_spart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rda = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rda_ack;
    logic       pop = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    logic [7:0] exp_q[$];

    spart_rx_fifo #(.DATA_W(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rda      (rda),
        .rx_data  (rx_data),
        .rda_ack  (rda_ack),
        .pop      (pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    // Monitor: every rd_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && rda_ack) ack_cnt++;
        if (rst_n && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid with rd_data=%02h, no read expected", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %02h expected %02h", rd_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rda = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rda = 1'b0;
    endtask

    task automatic pop_byte(input logic [7:0] expected);
        @(posedge clk); #1;
        pop = 1'b1;
        exp_q.push_back(expected);
        @(posedge clk); #1;
        pop = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ack0;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rda_ack", rda_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three bytes in, three out
        ack0 = ack_cnt;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        settle();
        check("abc_count", count, 3);
        check("abc_acks", ack_cnt - ack0, 3);
        pop_byte(8'h41);
        pop_byte(8'h42);
        pop_byte(8'h43);
        settle();
        check("abc_empty", empty, 1);

        // Nine pushes into eight slots
        ack0 = ack_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        settle();
        check("fill_full", full, 1);
        check("fill_ovf_clear", overflow, 0);
        push_byte(8'h08);
        settle();
        check("drop_overflow", overflow, 1);
        check("drop_count", count, 8);
        check("drop_acks", ack_cnt - ack0, 9);

        // Clear overflow, then push and pop together while full
        @(posedge clk); #1;
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        settle();
        check("clr_ovf", overflow, 0);
        @(posedge clk); #1;
        rda = 1'b1;
        rx_data = 8'hAA;
        pop = 1'b1;
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        rda = 1'b0;
        pop = 1'b0;
        settle();
        check("full_pp_count", count, 8);
        check("full_pp_ovf", overflow, 0);
        for (int i = 1; i < 8; i++) pop_byte(8'(i));
        pop_byte(8'hAA);
        settle();
        check("full_pp_empty", empty, 1);

        // Push and pop together while empty: pop ignored
        @(posedge clk); #1;
        rda = 1'b1;
        rx_data = 8'h55;
        pop = 1'b1;
        @(posedge clk); #1;
        rda = 1'b0;
        pop = 1'b0;
        settle();
        check("empty_pp_count", count, 1);
        pop_byte(8'h55);
        settle();
        check("empty_pp_drained", count, 0);

        // Long rda level produces one push only
        ack0 = ack_cnt;
        @(posedge clk); #1;
        rda = 1'b1;
        rx_data = 8'h7E;
        repeat (50) @(posedge clk);
        #1;
        rda = 1'b0;
        settle();
        check("hold_count", count, 1);
        check("hold_acks", ack_cnt - ack0, 1);
        pop_byte(8'h7E);

        // 20 push/pop rounds wrap both pointers
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h10 + 8'(i));
            pop_byte(8'h10 + 8'(i));
        end
        settle();
        check("wrap_empty", empty, 1);

        // Fill, then a drop coinciding with clr_ovf
        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
        @(posedge clk); #1;
        rda = 1'b1;
        rx_data = 8'h99;
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        rda = 1'b0;
        clr_ovf = 1'b0;
        settle();
        check("set_wins_ovf", overflow, 1);
        pop_byte(8'h20);
        pop_byte(8'h21);
        pop_byte(8'h22);
        settle();
        check("pre_rst_count", count, 5);
        check("pre_rst_ovf", overflow, 1);

        // Asynchronous reset mid-cycle
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_overflow", overflow, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_byte(8'h3C);
        pop_byte(8'h3C);
        settle();
        settle();
        check("post_rst_empty", empty, 1);
        check("pending_reads", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spart_rx_fifo
